// File: rtl/iterative_divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and counter sizing.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: $clog2(width) holds width-1 (width >= 2).
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/iterative_divider_addsub.sv
// Combinational add/subtract unit; of_uf is carry-out on add, borrow on subtract.
module iterative_divider_addsub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_op,     // 1 = add, 0 = subtract
    output logic [WIDTH-1:0] o_result,
    output logic             o_of_uf
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        if (i_op) w_sum = {1'b0, i_a} + {1'b0, i_b};
        else      w_sum = {1'b0, i_a} - {1'b0, i_b};
    end

    assign o_result = w_sum[WIDTH-1:0];
    assign o_of_uf  = w_sum[WIDTH];

endmodule

// File: rtl/iterative_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

    state_t           r_state;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [W:0]       w_trial;
    logic             w_borrow;

    iterative_divider_addsub #(
        .WIDTH (W + 1)
    ) u_sub (
        .i_a      ({r_rem, r_quo[W-1]}),
        .i_b      ({1'b0, r_div}),
        .i_op     (1'b0),
        .o_result (w_trial),
        .o_of_uf  (w_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_quo      <= operand_a;
                        r_div      <= operand_b;
                        r_rem      <= '0;
                        r_dbz      <= (operand_b == '0);
                        r_cnt      <= (operand_b == '0) ? '0 : CNT_INIT;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor spends one cycle here to load the fixed result.
                    if (r_dbz) begin
                        r_quo <= '1;
                        r_rem <= r_quo;
                    end else begin
                        r_rem <= w_borrow ? {r_rem[W-2:0], r_quo[W-1]} : w_trial[W-1:0];
                        r_quo <= {r_quo[W-2:0], ~w_borrow};
                    end
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and sweep checks for iterative_divider at DATA_WIDTH=8.
module tb_iterative_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] operand_a = '0;
    logic [7:0] operand_b = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad = 0;

    iterative_divider #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one operand pair for one edge, then scramble the operands.
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = ~a;
        operand_b = b + 8'd1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d dbz=%b, want rdy=1 vld=0 q=0 r=0 dbz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int n;
        out_ready = 1'b1;
        accept(8'd100, 8'd7);
        wait_valid(n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d cycles, want 8", n);
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        int busy_seen;
        out_ready = 1'b1;
        accept(8'd255, 8'd1);
        busy_seen = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) busy_seen++;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy_seen !== 0 || n !== 8) begin
            bad++;
            $display("FAIL b2b_calc1: in_ready high %0d cycles, latency %0d, want 0 and 8", busy_seen, n);
        end
        total++;
        if ({quotient, remainder} !== {8'd255, 8'd0}) begin
            bad++;
            $display("FAIL b2b_result1: q=%0d r=%0d, want q=255 r=0", quotient, remainder);
        end
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_bubble: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        accept(8'd5, 8'd9);
        busy_seen = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) busy_seen++;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy_seen !== 0 || n !== 8) begin
            bad++;
            $display("FAIL b2b_calc2: in_ready high %0d cycles, latency %0d, want 0 and 8", busy_seen, n);
        end
        total++;
        if ({quotient, remainder} !== {8'd0, 8'd5}) begin
            bad++;
            $display("FAIL b2b_result2: q=%0d r=%0d, want q=0 r=5", quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int n;
        out_ready = 1'b1;
        accept(8'd42, 8'd0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL dz_early: out_valid=%b right after accept, want 0", out_valid);
        end
        wait_valid(n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL dz_latency: got %0d cycles, want 1", n);
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd42, 1'b1}) begin
            bad++;
            $display("FAIL dz_result: q=%0d r=%0d dbz=%b, want q=255 r=42 dbz=1", quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int n;
        int drift;
        out_ready = 1'b0;
        accept(8'd200, 8'd3);
        wait_valid(n);
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd66, 8'd2, 1'b0}) begin
            bad++;
            $display("FAIL stall_result: q=%0d r=%0d dbz=%b, want q=66 r=2 dbz=0", quotient, remainder, div_by_zero);
        end
        drift = 0;
        for (int i = 0; i < 5; i++) begin
            operand_a = 8'd17 + 8'(i);
            operand_b = 8'd1;
            in_valid  = i[0];
            @(posedge clk); #1;
            if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'd66, 8'd2}) drift++;
        end
        in_valid = 1'b0;
        total++;
        if (drift !== 0) begin
            bad++;
            $display("FAIL stall_hold: %0d cycles changed, want 0 (vld=%b rdy=%b q=%0d r=%0d)",
                     drift, out_valid, in_ready, quotient, remainder);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stall_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_calc;
        int n;
        out_ready = 1'b1;
        accept(8'd200, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL midreset: rdy=%b vld=%b q=%0d r=%0d dbz=%b, want rdy=1 vld=0 q=0 r=0 dbz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept(8'd9, 8'd4);
        wait_valid(n);
        total++;
        if ({n[7:0], quotient, remainder, div_by_zero} !== {8'd8, 8'd2, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=2 r=1 dbz=0",
                     n, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int n;
        int a;
        int b;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            case (i % 8)
                0: b = 0;
                1: a = 0;
                2: a = 255;
                3: b = 255;
                default: ;
            endcase
            accept(8'(a), 8'(b));
            wait_valid(n);
            total++;
            if (n >= 40) begin
                bad++;
                $display("FAIL rand_timeout: %0d/%0d no out_valid after %0d cycles, want <= 8", a, b, n);
            end else if (b == 0) begin
                if ({quotient, remainder, div_by_zero} !== {8'd255, 8'(a), 1'b1}) begin
                    bad++;
                    $display("FAIL rand_dz: %0d/0 gave q=%0d r=%0d dbz=%b, want q=255 r=%0d dbz=1",
                             a, quotient, remainder, div_by_zero, a);
                end
            end else if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b
                         || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL rand_div: %0d/%0d gave q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                         a, b, quotient, remainder, div_by_zero, a / b, a % b);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_stall();
        test_reset_mid_calc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
